// File: rtl/sw_pkg.sv
// Shared definitions for the switch packet transmitter and the switch-side checkers.
//   sw_state_e    : transmitter FSM states, in frame order
//   HDR_*_OFS     : word offsets of DA/SA/LEN inside the frame header
//   DEF_*         : default width/depth used when a parent does not override them
package sw_pkg;

  localparam int DEF_WORD_WIDTH = 8;
  localparam int DEF_FIFO_SIZE  = 64;

  localparam int HDR_DA_OFS  = 0;
  localparam int HDR_SA_OFS  = 1;
  localparam int HDR_LEN_OFS = 2;
  localparam int HDR_WORDS   = 3;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_DA, S_SA, S_LEN, S_PAY, S_PAR, S_GAP
  } sw_state_e;

endpackage

// File: rtl/sw_tx_fifo.sv
// Synchronous payload FIFO, FIFO_SIZE x WORD_WIDTH, for sw_pkt_tx.
//   push_i/wdata_i : write one word (caller guarantees not full)
//   pop_i          : drop the head word (caller guarantees not empty)
//   rdata_o        : current head word, combinational from storage (no lookahead reg)
//   level_o        : words held, 0..FIFO_SIZE inclusive
//   full_o         : level_o == FIFO_SIZE
module sw_tx_fifo #(
  parameter int FIFO_SIZE  = 64,
  parameter int WORD_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push_i,
  input  logic [WORD_WIDTH-1:0]         wdata_i,
  input  logic                          pop_i,
  output logic [WORD_WIDTH-1:0]         rdata_o,
  output logic [$clog2(FIFO_SIZE):0]    level_o,
  output logic                          full_o
);

  localparam int AW = $clog2(FIFO_SIZE);
  localparam int LW = AW + 1;

  logic [WORD_WIDTH-1:0] mem [FIFO_SIZE];
  logic [AW-1:0]         wptr_q, rptr_q;
  logic [LW-1:0]         level_q, level_d;

  // Pointers are exactly AW bits wide, so wrap modulo FIFO_SIZE is free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + AW'(1);
      if (pop_i)  rptr_q <= rptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem[wptr_q] <= wdata_i;
  end

  always_comb begin
    level_d = level_q;
    case ({push_i, pop_i})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  assign rdata_o = mem[rptr_q];
  assign level_o = level_q;
  assign full_o  = (level_q == LW'(FIFO_SIZE));

endmodule

// File: rtl/sw_pkt_tx.sv
// Switch ingress packet transmitter. Buffers payload bytes from a valid/ready
// stream and sends one contiguous frame DA, SA, LEN, payload[LEN] on
// sw_enable_out/data_out, followed by IPG_CYCLES idle cycles.
//   pkt_start/pkt_da/pkt_sa/pkt_len : send request, taken only while tx_ready
//   tx_ready                        : high in IDLE
//   pl_valid/pl_data/pl_ready       : payload push stream into the FIFO
//   sw_enable_out/data_out          : frame to switch ingress (registered)
//   pkt_done                        : pulse with the first idle cycle after a frame
//   pkt_err                         : pulse when a start asks for more than FIFO_SIZE bytes
//   fifo_level                      : bytes held in the payload FIFO
// Build option: define SW_TX_PARITY_EN to append an XOR parity byte
// (DA^SA^LEN^payload) after the last payload byte.
module sw_pkt_tx
  import sw_pkg::*;
#(
  parameter int FIFO_SIZE  = DEF_FIFO_SIZE,
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int IPG_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pkt_start,
  input  logic [WORD_WIDTH-1:0]      pkt_da,
  input  logic [WORD_WIDTH-1:0]      pkt_sa,
  input  logic [WORD_WIDTH-1:0]      pkt_len,
  output logic                       tx_ready,
  input  logic                       pl_valid,
  input  logic [WORD_WIDTH-1:0]      pl_data,
  output logic                       pl_ready,
  output logic                       sw_enable_out,
  output logic [WORD_WIDTH-1:0]      data_out,
  output logic                       pkt_done,
  output logic                       pkt_err,
  output logic [$clog2(FIFO_SIZE):0] fifo_level
);

  localparam int LW = $clog2(FIFO_SIZE) + 1;
  // Common width for comparing a byte count against the FIFO level/depth.
  localparam int CW = ((WORD_WIDTH > LW) ? WORD_WIDTH : LW) + 1;
  localparam int GW = $clog2(IPG_CYCLES + 1);

`ifdef SW_TX_PARITY_EN
  localparam sw_state_e PAY_NEXT = S_PAR;
`else
  localparam sw_state_e PAY_NEXT = S_GAP;
`endif

  sw_state_e                              state_q, state_d;
  logic [HDR_WORDS-1:0][WORD_WIDTH-1:0]   hdr_q, hdr_d;
  logic [WORD_WIDTH-1:0]                  cnt_q, cnt_d;
  logic [GW-1:0]                          gap_q, gap_d;
  logic                                   en_q, en_d;
  logic [WORD_WIDTH-1:0]                  data_q, data_d;
  logic                                   done_q, done_d;
  logic                                   err_q, err_d;
`ifdef SW_TX_PARITY_EN
  logic [WORD_WIDTH-1:0]                  par_q, par_d;
`endif

  logic                  push, pop, full;
  logic [WORD_WIDTH-1:0] rdata;
  logic                  len_ok, lvl_ok;

  assign push     = pl_valid & pl_ready;
  assign pl_ready = ~full;
  assign tx_ready = (state_q == S_IDLE);

  assign len_ok = CW'(pkt_len) <= CW'(FIFO_SIZE);
  // Only start the frame once every payload byte is already buffered, so the
  // enable never drops mid-frame regardless of upstream pacing.
  assign lvl_ok = CW'(fifo_level) >= CW'(hdr_q[HDR_LEN_OFS]);

  sw_tx_fifo #(.FIFO_SIZE(FIFO_SIZE), .WORD_WIDTH(WORD_WIDTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (pl_data),
    .pop_i   (pop),
    .rdata_o (rdata),
    .level_o (fifo_level),
    .full_o  (full)
  );

  // Outputs are computed from the current state and registered, so the wire
  // frame trails the FSM by one cycle.
  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    cnt_d   = cnt_q;
    gap_d   = '0;
    pop     = 1'b0;
    en_d    = 1'b0;
    data_d  = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef SW_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pkt_start) begin
          if (len_ok) begin
            hdr_d[HDR_DA_OFS]  = pkt_da;
            hdr_d[HDR_SA_OFS]  = pkt_sa;
            hdr_d[HDR_LEN_OFS] = pkt_len;
            cnt_d              = pkt_len;
`ifdef SW_TX_PARITY_EN
            par_d              = pkt_da ^ pkt_sa ^ pkt_len;
`endif
            state_d            = S_WAIT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_WAIT: if (lvl_ok) state_d = S_DA;
      S_DA: begin
        en_d    = 1'b1;
        data_d  = hdr_q[HDR_DA_OFS];
        state_d = S_SA;
      end
      S_SA: begin
        en_d    = 1'b1;
        data_d  = hdr_q[HDR_SA_OFS];
        state_d = S_LEN;
      end
      S_LEN: begin
        en_d    = 1'b1;
        data_d  = hdr_q[HDR_LEN_OFS];
        state_d = (cnt_q == '0) ? PAY_NEXT : S_PAY;
      end
      S_PAY: begin
        en_d   = 1'b1;
        pop    = 1'b1;
        data_d = rdata;
        cnt_d  = cnt_q - WORD_WIDTH'(1);
`ifdef SW_TX_PARITY_EN
        par_d  = par_q ^ rdata;
`endif
        if (cnt_q == WORD_WIDTH'(1)) state_d = PAY_NEXT;
      end
      S_PAR: begin
`ifdef SW_TX_PARITY_EN
        en_d   = 1'b1;
        data_d = par_q;
`endif
        state_d = S_GAP;
      end
      S_GAP: begin
        done_d = (gap_q == '0);
        gap_d  = gap_q + GW'(1);
        if (gap_q == GW'(IPG_CYCLES - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hdr_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      en_q    <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef SW_TX_PARITY_EN
      par_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      en_q    <= en_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef SW_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign sw_enable_out = en_q;
  assign data_out      = data_q;
  assign pkt_done      = done_q;
  assign pkt_err       = err_q;

endmodule

// File: tb/tb_sw_pkt_tx.sv
module tb_sw_pkt_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pkt_start;
  logic [7:0] pkt_da, pkt_sa, pkt_len;
  logic       tx_ready;
  logic       pl_valid;
  logic [7:0] pl_data;
  logic       pl_ready;
  logic       sw_enable_out;
  logic [7:0] data_out;
  logic       pkt_done, pkt_err;
  logic [6:0] fifo_level;

  int checks = 0;
  int errors = 0;

  // monitor state (written only by the monitor)
  int         cyc = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] fr_b[$];
  int         fr_c[$];

  sw_pkt_tx dut (
    .clk(clk), .rst_n(rst_n), .pkt_start(pkt_start), .pkt_da(pkt_da), .pkt_sa(pkt_sa),
    .pkt_len(pkt_len), .tx_ready(tx_ready), .pl_valid(pl_valid), .pl_data(pl_data),
    .pl_ready(pl_ready), .sw_enable_out(sw_enable_out), .data_out(data_out),
    .pkt_done(pkt_done), .pkt_err(pkt_err), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (sw_enable_out === 1'b1) begin
      fr_b.push_back(data_out);
      fr_c.push_back(cyc);
    end
    if (pkt_done === 1'b1) done_cnt++;
    if (pkt_err === 1'b1) err_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; pkt_start = 1'b0; pl_valid = 1'b0;
    pkt_da = '0; pkt_sa = '0; pkt_len = '0; pl_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    pl_valid = 1'b1; pl_data = b;
    while (pl_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL push_timeout: pl_ready stuck at %b, required 1", pl_ready);
    end
    @(negedge clk);
    pl_valid = 1'b0;
  endtask

  task automatic start_pkt(input logic [7:0] da, input logic [7:0] sa, input logic [7:0] len);
    pkt_start = 1'b1; pkt_da = da; pkt_sa = sa; pkt_len = len;
    @(negedge clk);
    pkt_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (pkt_done === 1'b1) begin ok = 1'b1; break; end
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (sw_enable_out !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", sw_enable_out); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_out); end
    checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", pkt_done); end
    checks++; if (pkt_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", pkt_err); end
    checks++; if (fifo_level !== 7'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_txrdy: got %b want 1", tx_ready); end
    checks++; if (pl_ready !== 1'b1) begin errors++; $display("FAIL reset_plrdy: got %b want 1", pl_ready); end
  endtask

  task automatic test_basic();
    logic [7:0] exp[$];
    logic [7:0] p;
    int base, dbase, n;
    bit ok;
    exp = '{8'h01, 8'hAA, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
`ifdef SW_TX_PARITY_EN
    p = '0; foreach (exp[i]) p ^= exp[i]; exp.push_back(p);
`endif
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    checks++; if (fifo_level !== 7'd4) begin errors++; $display("FAIL basic_level4: got %0d want 4", fifo_level); end
    base = fr_b.size(); dbase = done_cnt;
    start_pkt(8'h01, 8'hAA, 8'h04);
    @(negedge clk);
    checks++; if (sw_enable_out !== 1'b0) begin errors++; $display("FAIL basic_lat_early: en %b want 0", sw_enable_out); end
    @(negedge clk);
    checks++; if (sw_enable_out !== 1'b1 || data_out !== 8'h01) begin errors++; $display("FAIL basic_lat_da: en %b data %h want 1/01", sw_enable_out, data_out); end
    wait_done(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_done_timeout: no pkt_done"); end
    checks++; if (sw_enable_out !== 1'b0) begin errors++; $display("FAIL basic_gap_en: got %b want 0", sw_enable_out); end
    checks++; if (fifo_level !== 7'd0) begin errors++; $display("FAIL basic_level0: got %0d want 0", fifo_level); end
    n = fr_b.size() - base;
    checks++; if (n != exp.size()) begin errors++; $display("FAIL basic_len: got %0d bytes want %0d", n, exp.size()); end
    for (int i = 0; i < exp.size() && i < n; i++) begin
      checks++; if (fr_b[base+i] !== exp[i]) begin errors++; $display("FAIL basic_byte%0d: got %h want %h", i, fr_b[base+i], exp[i]); end
    end
    checks++; if (n > 0 && fr_c[base+n-1] - fr_c[base] != n - 1) begin errors++; $display("FAIL basic_contig: span %0d want %0d", fr_c[base+n-1] - fr_c[base], n - 1); end
    repeat (5) @(negedge clk);
    #1;
    checks++; if (done_cnt - dbase != 1) begin errors++; $display("FAIL basic_done_once: got %0d pulses want 1", done_cnt - dbase); end
  endtask

  task automatic test_wait();
    logic [7:0] exp[$];
    logic [7:0] p;
    int base, n, bad;
    bit ok;
    exp = '{8'h02, 8'hBB, 8'h03, 8'h51, 8'h52, 8'h53};
`ifdef SW_TX_PARITY_EN
    p = '0; foreach (exp[i]) p ^= exp[i]; exp.push_back(p);
`endif
    base = fr_b.size();
    start_pkt(8'h02, 8'hBB, 8'h03);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_ready !== 1'b0 || sw_enable_out !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL wait_hold: %0d bad cycles want 0", bad); end
    push_byte(8'h51); push_byte(8'h52); push_byte(8'h53);
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL wait_txrdy: got %b want 0", tx_ready); end
    wait_done(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wait_done_timeout: no pkt_done"); end
    n = fr_b.size() - base;
    checks++; if (n != exp.size()) begin errors++; $display("FAIL wait_len: got %0d bytes want %0d", n, exp.size()); end
    for (int i = 0; i < exp.size() && i < n; i++) begin
      checks++; if (fr_b[base+i] !== exp[i]) begin errors++; $display("FAIL wait_byte%0d: got %h want %h", i, fr_b[base+i], exp[i]); end
    end
    checks++; if (n > 0 && fr_c[base+n-1] - fr_c[base] != n - 1) begin errors++; $display("FAIL wait_contig: span %0d want %0d", fr_c[base+n-1] - fr_c[base], n - 1); end
  endtask

  task automatic test_zero_len();
    logic [7:0] exp[$];
    int base, n;
    bit ok;
    exp = '{8'h03, 8'hCC, 8'h00};
`ifdef SW_TX_PARITY_EN
    exp.push_back(8'hCF);
`endif
    base = fr_b.size();
    start_pkt(8'h03, 8'hCC, 8'h00);
    wait_done(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL zero_done_timeout: no pkt_done"); end
    n = fr_b.size() - base;
    checks++; if (n != exp.size()) begin errors++; $display("FAIL zero_len: got %0d bytes want %0d", n, exp.size()); end
    for (int i = 0; i < exp.size() && i < n; i++) begin
      checks++; if (fr_b[base+i] !== exp[i]) begin errors++; $display("FAIL zero_byte%0d: got %h want %h", i, fr_b[base+i], exp[i]); end
    end
    checks++; if (fifo_level !== 7'd0) begin errors++; $display("FAIL zero_level: got %0d want 0", fifo_level); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp[$];
    logic [7:0] p;
    int base, ebase, n, k, bad;
    bit ok;
    base = fr_b.size(); ebase = err_cnt;
    pkt_start = 1'b1; pkt_da = 8'h04; pkt_sa = 8'hDD; pkt_len = 8'd65;
    @(negedge clk);
    pkt_start = 1'b0;
    checks++; if (pkt_err !== 1'b1) begin errors++; $display("FAIL ovf_err_pulse: got %b want 1", pkt_err); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL ovf_idle: tx_ready %b want 1", tx_ready); end
    @(negedge clk);
    checks++; if (pkt_err !== 1'b0) begin errors++; $display("FAIL ovf_err_width: got %b want 0", pkt_err); end
    repeat (8) @(negedge clk);
    #1;
    checks++; if (fr_b.size() != base || err_cnt - ebase != 1) begin errors++; $display("FAIL ovf_noframe: bytes %0d errs %0d want 0/1", fr_b.size() - base, err_cnt - ebase); end
    @(negedge clk);
    for (int i = 0; i < 64; i++) push_byte(8'(i));
    checks++; if (fifo_level !== 7'd64) begin errors++; $display("FAIL ovf_full_level: got %0d want 64", fifo_level); end
    checks++; if (pl_ready !== 1'b0) begin errors++; $display("FAIL ovf_full_ready: got %b want 0", pl_ready); end
    // keep pushing while the full FIFO drains: level must sit at 63 during payload
    exp = '{8'h04, 8'hDD, 8'h40};
    for (int i = 0; i < 64; i++) exp.push_back(8'(i));
`ifdef SW_TX_PARITY_EN
    p = '0; foreach (exp[i]) p ^= exp[i]; exp.push_back(p);
`endif
    base = fr_b.size();
    pl_valid = 1'b1; pl_data = 8'hE0;
    start_pkt(8'h04, 8'hDD, 8'h40);
    ok = 1'b0; k = 0; bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sw_enable_out === 1'b1) begin
        if (k >= 3 && k < 67 && fifo_level !== 7'd63) bad++;
        k++;
      end
      if (pkt_done === 1'b1) begin ok = 1'b1; break; end
    end
    pl_valid = 1'b0;
    #1;
    checks++; if (!ok) begin errors++; $display("FAIL ovf_done_timeout: no pkt_done"); end
    checks++; if (bad != 0) begin errors++; $display("FAIL ovf_pushpop_level: %0d samples off 63", bad); end
    n = fr_b.size() - base;
    checks++; if (n != exp.size()) begin errors++; $display("FAIL ovf_len: got %0d bytes want %0d", n, exp.size()); end
    for (int i = 0; i < exp.size() && i < n; i++) begin
      checks++; if (fr_b[base+i] !== exp[i]) begin errors++; $display("FAIL ovf_byte%0d: got %h want %h", i, fr_b[base+i], exp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[$];
    logic [7:0] p;
    int base, ebase, n;
    bit ok;
    do_reset();
    for (int i = 0; i < 6; i++) push_byte(8'h61 + 8'(i));
    exp = '{8'h05, 8'hEE, 8'h04, 8'h61, 8'h62, 8'h63, 8'h64};
`ifdef SW_TX_PARITY_EN
    p = '0; foreach (exp[i]) p ^= exp[i]; exp.push_back(p);
`endif
    base = fr_b.size(); ebase = err_cnt;
    start_pkt(8'h05, 8'hEE, 8'h04);
    start_pkt(8'h07, 8'h77, 8'h02);
    wait_done(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_done_timeout: no pkt_done"); end
    checks++; if (fifo_level !== 7'd2) begin errors++; $display("FAIL b2b_level: got %0d want 2", fifo_level); end
    repeat (10) @(negedge clk);
    #1;
    n = fr_b.size() - base;
    checks++; if (n != exp.size()) begin errors++; $display("FAIL b2b_len1: got %0d bytes want %0d", n, exp.size()); end
    for (int i = 0; i < exp.size() && i < n; i++) begin
      checks++; if (fr_b[base+i] !== exp[i]) begin errors++; $display("FAIL b2b_a_byte%0d: got %h want %h", i, fr_b[base+i], exp[i]); end
    end
    checks++; if (err_cnt != ebase) begin errors++; $display("FAIL b2b_noerr: got %0d errs want 0", err_cnt - ebase); end
    exp = '{8'h08, 8'h99, 8'h02, 8'h65, 8'h66};
`ifdef SW_TX_PARITY_EN
    p = '0; foreach (exp[i]) p ^= exp[i]; exp.push_back(p);
`endif
    base = fr_b.size();
    start_pkt(8'h08, 8'h99, 8'h02);
    wait_done(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_done2_timeout: no pkt_done"); end
    n = fr_b.size() - base;
    checks++; if (n != exp.size()) begin errors++; $display("FAIL b2b_len2: got %0d bytes want %0d", n, exp.size()); end
    for (int i = 0; i < exp.size() && i < n; i++) begin
      checks++; if (fr_b[base+i] !== exp[i]) begin errors++; $display("FAIL b2b_b_byte%0d: got %h want %h", i, fr_b[base+i], exp[i]); end
    end
    checks++; if (fifo_level !== 7'd0) begin errors++; $display("FAIL b2b_level0: got %0d want 0", fifo_level); end
  endtask

  task automatic test_reset_mid();
    int base, dbase, k;
    do_reset();
    for (int i = 0; i < 8; i++) push_byte(8'hA0 + 8'(i));
    base = fr_b.size(); dbase = done_cnt;
    start_pkt(8'h09, 8'h11, 8'h08);
    k = 0;
    while (fr_b.size() - base < 5 && k < 50) begin @(negedge clk); #1; k++; end
    checks++; if (k >= 50) begin errors++; $display("FAIL rmid_timeout: frame reached %0d bytes, want 5", fr_b.size() - base); end
    checks++; if (sw_enable_out !== 1'b1) begin errors++; $display("FAIL rmid_inpay: en %b want 1", sw_enable_out); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (sw_enable_out !== 1'b0) begin errors++; $display("FAIL rmid_en: got %b want 0", sw_enable_out); end
    checks++; if (fifo_level !== 7'd0) begin errors++; $display("FAIL rmid_level: got %0d want 0", fifo_level); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rmid_txrdy: got %b want 1", tx_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = fr_b.size();
    repeat (20) @(negedge clk);
    #1;
    checks++; if (done_cnt != dbase) begin errors++; $display("FAIL rmid_nodone: got %0d pulses want 0", done_cnt - dbase); end
    checks++; if (fr_b.size() != base) begin errors++; $display("FAIL rmid_noframe: got %0d bytes want 0", fr_b.size() - base); end
  endtask

  initial begin
    rst_n = 1'b0; pkt_start = 1'b0; pl_valid = 1'b0;
    pkt_da = '0; pkt_sa = '0; pkt_len = '0; pl_data = '0;
    test_reset();
    test_basic();
    test_wait();
    test_zero_len();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
